// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_unit
//  Purpose  : ID-stage branch resolution with a 2-bit saturating-counter BHT
//             and wrap-around branch / mispredict statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int WIDTH     = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [2:0]       id_br_type,
  input  logic [PC_W-1:0]  id_pc,
  input  logic [PC_W-1:0]  id_target,
  input  logic             id_pred_taken,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             branch_taken,
  output logic             mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);

  localparam int         c_IDX_W   = $clog2(BHT_DEPTH);
  localparam logic [2:0] c_BR_BEQ  = 3'b001;
  localparam logic [2:0] c_BR_BNE  = 3'b010;
  localparam logic [2:0] c_BR_BLEZ = 3'b011;
  localparam logic [2:0] c_BR_BGTZ = 3'b100;
  localparam logic [2:0] c_BR_BLTZ = 3'b101;
  localparam logic [2:0] c_BR_BGEZ = 3'b110;
  localparam logic [1:0] c_WEAK_NT = 2'b01;

  logic [1:0]         r_bht [BHT_DEPTH];
  logic [CNT_W-1:0]   r_brCount;
  logic [CNT_W-1:0]   r_mpCount;

  logic               w_isBr;
  logic               w_cond;
  logic               w_rsNeg;
  logic               w_rsZero;
  logic               w_resolve;
  logic [c_IDX_W-1:0] w_ifIdx;
  logic [c_IDX_W-1:0] w_idIdx;
  logic [1:0]         w_idCtr;
  logic [1:0]         w_idCtrNext;
  logic               w_unusedBits;

  assign w_ifIdx  = if_pc[c_IDX_W+1:2];
  assign w_idIdx  = id_pc[c_IDX_W+1:2];
  assign w_rsNeg  = rs_data[WIDTH-1];
  assign w_rsZero = (rs_data == '0);

  // Fetch-side lookup reads the registered table only: a same-cycle update is not bypassed.
  assign if_pred_taken = r_bht[w_ifIdx][1];

  // Types 000 and 111 fall to the default and are treated as non-branches.
  always_comb begin
    w_isBr = 1'b0;
    w_cond = 1'b0;
    case (id_br_type)
      c_BR_BEQ:  begin w_isBr = id_valid; w_cond = (rs_data == rt_data); end
      c_BR_BNE:  begin w_isBr = id_valid; w_cond = (rs_data != rt_data); end
      c_BR_BLEZ: begin w_isBr = id_valid; w_cond = w_rsNeg | w_rsZero;   end
      c_BR_BGTZ: begin w_isBr = id_valid; w_cond = ~w_rsNeg & ~w_rsZero; end
      c_BR_BLTZ: begin w_isBr = id_valid; w_cond = w_rsNeg;              end
      c_BR_BGEZ: begin w_isBr = id_valid; w_cond = ~w_rsNeg;             end
      default:   begin w_isBr = 1'b0;     w_cond = 1'b0;                 end
    endcase
  end

  assign branch_taken = w_isBr & w_cond;
  assign mispredict   = w_isBr & (branch_taken != id_pred_taken);
  assign redirect_pc  = branch_taken ? id_target : (id_pc + PC_W'(4));
  assign w_resolve    = w_isBr & ~id_stall;

  assign w_idCtr = r_bht[w_idIdx];

  always_comb begin
    w_idCtrNext = w_idCtr;
    if (branch_taken) begin
      if (w_idCtr != 2'b11) w_idCtrNext = w_idCtr + 2'b01;
    end else begin
      if (w_idCtr != 2'b00) w_idCtrNext = w_idCtr - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_DEPTH; i++) r_bht[i] <= c_WEAK_NT;
      r_brCount <= '0;
      r_mpCount <= '0;
    end else if (w_resolve) begin
      r_bht[w_idIdx] <= w_idCtrNext;
      r_brCount      <= r_brCount + CNT_W'(1);
      r_mpCount      <= r_mpCount + CNT_W'(mispredict);
    end
  end

  assign br_count = r_brCount;
  assign mp_count = r_mpCount;

  // Fetch PC bits outside the table index play no part in the lookup.
  assign w_unusedBits = ^{if_pc[PC_W-1:c_IDX_W+2], if_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_unit
//  Purpose  : Scoreboard bench for branch_resolve_unit (CNT_W = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam logic [2:0] c_NONE = 3'b000, c_BEQ = 3'b001, c_BNE = 3'b010, c_BLEZ = 3'b011;
  localparam logic [2:0] c_BGTZ = 3'b100, c_BLTZ = 3'b101, c_BGEZ = 3'b110, c_RSVD = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic        id_valid, id_stall, id_pred_taken;
  logic [2:0]  id_br_type;
  logic [31:0] id_pc, id_target, rs_data, rt_data;
  logic        branch_taken, mispredict;
  logic [31:0] redirect_pc;
  logic [3:0]  br_count, mp_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        taken;
    logic        misp;
    logic [31:0] redir;
    logic        pred;
    logic [3:0]  br;
    logic [3:0]  mp;
  } exp_t;

  exp_t sbq[$];

  branch_resolve_unit #(.WIDTH(32), .PC_W(32), .BHT_DEPTH(16), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .id_valid(id_valid), .id_stall(id_stall), .id_br_type(id_br_type),
    .id_pc(id_pc), .id_target(id_target), .id_pred_taken(id_pred_taken),
    .rs_data(rs_data), .rt_data(rt_data), .branch_taken(branch_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
    end
  endtask

  // Monitor: combinational outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.name, "taken",  32'(branch_taken),  32'(e.taken));
      chk(e.name, "misp",   32'(mispredict),    32'(e.misp));
      chk(e.name, "redir",  redirect_pc,        e.redir);
      chk(e.name, "pred",   32'(if_pred_taken), 32'(e.pred));
      chk(e.name, "br",     32'(br_count),      32'(e.br));
      chk(e.name, "mp",     32'(mp_count),      32'(e.mp));
    end
  end

  task automatic cyc(input string nm, input logic rv, input logic v, input logic st,
                     input logic [2:0] ty, input logic [31:0] pc, input logic [31:0] tgt,
                     input logic pr, input logic [31:0] rs, input logic [31:0] rt,
                     input logic [31:0] ifp, input logic eT, input logic eM,
                     input logic [31:0] eR, input logic eP, input logic [3:0] eB,
                     input logic [3:0] eMp);
    exp_t e;
    @(posedge clk);
    rst_n = rv;
    #1;
    id_valid = v; id_stall = st; id_br_type = ty; id_pc = pc; id_target = tgt;
    id_pred_taken = pr; rs_data = rs; rt_data = rt; if_pc = ifp;
    e.name = nm; e.taken = eT; e.misp = eM; e.redir = eR; e.pred = eP; e.br = eB; e.mp = eMp;
    sbq.push_back(e);
  endtask

  task automatic idle(input string nm, input logic rv, input logic [31:0] ifp,
                      input logic eP, input logic [3:0] eB, input logic [3:0] eMp);
    cyc(nm, rv, 1'b0, 1'b0, c_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, ifp,
        1'b0, 1'b0, 32'h4, eP, eB, eMp);
  endtask

  // Stalled compare at pc 0x80: outputs only, no state change.
  task automatic sgn(input string nm, input logic [2:0] ty, input logic [31:0] rs,
                     input logic [31:0] rt, input logic pr, input logic eT);
    cyc(nm, 1'b1, 1'b1, 1'b1, ty, 32'h80, 32'h200, pr, rs, rt, 32'h40,
        eT, eT != pr, eT ? 32'h200 : 32'h84, 1'b1, 4'd1, 4'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_stall = 1'b0; id_br_type = c_NONE; id_pc = '0; id_target = '0;
    id_pred_taken = 1'b0; rs_data = '0; rt_data = '0; if_pc = '0;

    idle("in_reset", 1'b0, 32'h40, 1'b0, 4'd0, 4'd0);
    idle("in_reset", 1'b0, 32'h44, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 16; i++) idle($sformatf("sweep%0d", i), 1'b1, 32'(i * 4), 1'b0, 4'd0, 4'd0);

    // beq taken against a not-taken prediction at index 0
    cyc("beq_mp", 1, 1, 0, c_BEQ, 32'h40, 32'h100, 0, 32'h1234, 32'h1234, 32'h40,
        1, 1, 32'h100, 0, 4'd0, 4'd0);
    idle("beq_after", 1'b1, 32'h40, 1'b1, 4'd1, 4'd1);

    sgn("bltz_neg", c_BLTZ, 32'h8000_0000, 32'h0, 0, 1);
    sgn("blez_neg", c_BLEZ, 32'h8000_0000, 32'h0, 0, 1);
    sgn("bgez_neg", c_BGEZ, 32'h8000_0000, 32'h0, 0, 0);
    sgn("bgtz_neg", c_BGTZ, 32'h8000_0000, 32'h0, 0, 0);
    sgn("blez_zero", c_BLEZ, 32'h0, 32'h5, 0, 1);
    sgn("bgez_zero", c_BGEZ, 32'h0, 32'h5, 0, 1);
    sgn("bltz_zero", c_BLTZ, 32'h0, 32'h5, 0, 0);
    sgn("bgtz_zero", c_BGTZ, 32'h0, 32'h5, 0, 0);
    sgn("bgtz_pos", c_BGTZ, 32'h5, 32'h0, 1, 1);
    sgn("bne_diff", c_BNE, 32'h1, 32'h2, 0, 1);
    sgn("beq_diff", c_BEQ, 32'h1, 32'h2, 1, 0);
    idle("stall_nochg", 1'b1, 32'h40, 1'b1, 4'd1, 4'd1);

    // Saturation at index 2 (pc 0x48): 01 -> 10 -> 11 -> 11 ...
    cyc("sat1", 1, 1, 0, c_BEQ, 32'h48, 32'h300, 1, 32'h7, 32'h7, 32'h48, 1, 0, 32'h300, 0, 4'd1, 4'd1);
    cyc("sat2", 1, 1, 0, c_BEQ, 32'h48, 32'h300, 1, 32'h7, 32'h7, 32'h48, 1, 0, 32'h300, 1, 4'd2, 4'd1);
    cyc("sat3", 1, 1, 0, c_BEQ, 32'h48, 32'h300, 1, 32'h7, 32'h7, 32'h48, 1, 0, 32'h300, 1, 4'd3, 4'd1);
    cyc("sat4", 1, 1, 0, c_BEQ, 32'h48, 32'h300, 1, 32'h7, 32'h7, 32'h48, 1, 0, 32'h300, 1, 4'd4, 4'd1);
    cyc("sat5", 1, 1, 0, c_BEQ, 32'h48, 32'h300, 1, 32'h7, 32'h7, 32'h48, 1, 0, 32'h300, 1, 4'd5, 4'd1);
    cyc("nt1", 1, 1, 0, c_BNE, 32'h48, 32'h300, 1, 32'h7, 32'h7, 32'h48, 0, 1, 32'h4C, 1, 4'd6, 4'd1);
    cyc("nt2", 1, 1, 0, c_BNE, 32'h48, 32'h300, 0, 32'h7, 32'h7, 32'h48, 0, 0, 32'h4C, 1, 4'd7, 4'd2);
    idle("nt_after", 1'b1, 32'h48, 1'b0, 4'd8, 4'd2);

    // Branch held three cycles, then released: trained and counted once.
    for (int i = 0; i < 3; i++)
      cyc("held", 1, 1, 1, c_BGEZ, 32'h50, 32'h400, 0, 32'h0, 32'h0, 32'h50, 1, 1, 32'h400, 0, 4'd8, 4'd2);
    cyc("release", 1, 1, 0, c_BGEZ, 32'h50, 32'h400, 0, 32'h0, 32'h0, 32'h50, 1, 1, 32'h400, 0, 4'd8, 4'd2);
    idle("held_after1", 1'b1, 32'h50, 1'b1, 4'd9, 4'd3);
    idle("held_after2", 1'b1, 32'h50, 1'b1, 4'd9, 4'd3);

    cyc("rsvd", 1, 1, 0, c_RSVD, 32'h50, 32'h500, 1, 32'h3, 32'h3, 32'h50, 0, 0, 32'h54, 1, 4'd9, 4'd3);
    cyc("none", 1, 1, 0, c_NONE, 32'h50, 32'h500, 1, 32'h3, 32'h3, 32'h50, 0, 0, 32'h54, 1, 4'd9, 4'd3);
    cyc("invalid", 1, 0, 0, c_BEQ, 32'h50, 32'h500, 1, 32'h3, 32'h3, 32'h50, 0, 0, 32'h54, 1, 4'd9, 4'd3);
    idle("rsvd_after", 1'b1, 32'h50, 1'b1, 4'd9, 4'd3);

    // Drive br_count through 15 and wrap to 0 (index 8, pc 0x60).
    for (int j = 0; j < 7; j++)
      cyc($sformatf("wrap%0d", j), 1, 1, 0, c_BEQ, 32'h60, 32'h600, 1, 32'h9, 32'h9, 32'h60,
          1, 0, 32'h600, (j != 0), 4'(9 + j), 4'd3);
    idle("wrap_zero", 1'b1, 32'h60, 1'b1, 4'd0, 4'd3);

    // Reset lands on the edge that would commit this resolve.
    cyc("rst_edge_br", 1, 1, 0, c_BNE, 32'h60, 32'h600, 0, 32'h1, 32'h2, 32'h60, 1, 1, 32'h600, 1, 4'd0, 4'd3);
    idle("rst_mid1", 1'b0, 32'h60, 1'b0, 4'd0, 4'd0);
    idle("rst_mid2", 1'b0, 32'h40, 1'b0, 4'd0, 4'd0);
    cyc("post_rst_br", 1, 1, 0, c_BEQ, 32'h40, 32'h100, 0, 32'h5, 32'h5, 32'h40, 1, 1, 32'h100, 0, 4'd0, 4'd0);
    idle("post_rst_after", 1'b1, 32'h40, 1'b1, 4'd1, 4'd1);

    @(posedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
